// File: rtl/fp_div_pkg.sv
// Shared floating-point defines: special encodings, rounding codes, bias and rounding-increment helper.
package fp_div_pkg;

    localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
    localparam logic [31:0] FP_INFN  = 32'hFF80_0000;
    localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
    localparam logic [31:0] FP_ZERON = 32'h8000_0000;
    localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
    localparam logic [31:0] FP_NANS  = 32'h7FA0_0000;

    localparam logic [2:0] RNe = 3'd0;
    localparam logic [2:0] RZ  = 3'd1;
    localparam logic [2:0] RU  = 3'd2;
    localparam logic [2:0] RD  = 3'd3;
    localparam logic [2:0] RNa = 3'd4;

    localparam int unsigned FP_BIAS = 127;

    // Round-up decision shared by the fp multiplier and divider.
    function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                       input logic lsb, input logic g, input logic s);
        logic inc;
        inc = 1'b0;
        case (rm)
            RNe:     inc = g & (s | lsb);
            RNa:     inc = g;
            RZ:      inc = 1'b0;
            RU:      inc = ~sgn & (g | s);
            RD:      inc = sgn & (g | s);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_div_divxbit.sv
// divxbit: restoring mantissa divider, one quotient bit per enabled cycle (counterpart of mulxbit).
module divxbit #(
    parameter int unsigned MW = 24,
    parameter int unsigned QW = 26,
    parameter int unsigned CW = $clog2(QW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    output logic [QW-1:0] q,
    output logic          rem_nz_c,
    output logic          last_c
);

    logic [MW:0]   rem;
    logic [MW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic          ge;
    logic [MW:0]   rem_sub;

    // Remainder stays below 2*divisor, so MW+1 bits hold it across the shift.
    assign ge       = rem >= {1'b0, dvs};
    assign rem_sub  = ge ? (rem - {1'b0, dvs}) : rem;
    assign rem_nz_c = |rem;
    assign last_c   = cnt == CW'(QW - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= '0;
            dvs <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= {1'b0, a};
            dvs <= b;
            q   <= '0;
            cnt <= '0;
        end else if (en) begin
            rem <= {rem_sub[MW-1:0], 1'b0};
            q   <= {q[QW-2:0], ge};
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fp_div.sv
// fp_div: iterative IEEE single-style divider with five rounding modes and flush-to-zero.
// Optional dz flag output enabled by defining FP_DIV_DZ_FLAG_EN.
module fp_div
    import fp_div_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned M = 22,
    parameter int unsigned E = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [2:0]   round_m,
    output logic [W-1:0] out,
    output logic         ov,
    output logic         un,
    output logic         inv,
    output logic         inexact,
`ifdef FP_DIV_DZ_FLAG_EN
    output logic         dz,
`endif
    output logic         done,
    output logic         busy
);

    localparam int unsigned FW   = M + 1;
    localparam int unsigned EW   = E - M;
    localparam int unsigned MW   = M + 2;
    localparam int unsigned QW   = M + 4;
    localparam int unsigned XW   = EW + 2;
    localparam int unsigned EMAX = (1 << EW) - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          load_c, iter_c, last_c, rem_nz_c;
    logic [QW-1:0] quo;

    logic [EW-1:0] e1, e2;
    logic [FW-1:0] f1, f2;
    logic          nan1, nan2, inf1, inf2, zero1, zero2, sgn_c;
    logic          spc_c, spc_ov, spc_inv, spc_dz;
    logic [W-1:0]  spc_out;

    logic          sgn;
    logic [2:0]    rm;
    logic [XW-1:0] exp0;

    logic [MW-1:0] mant;
    logic [MW:0]   mant_r;
    logic [FW-1:0] frac;
    logic [XW-1:0] ex;
    logic          g, s, inc;
    logic [W-1:0]  rnd_out;
    logic          rnd_ov, rnd_un, rnd_inx;

    logic [W-1:0]  res_out;
    logic          res_ov, res_un, res_inv, res_inx, res_dz;

    assign e1    = in1[E:M+1];
    assign e2    = in2[E:M+1];
    assign f1    = in1[M:0];
    assign f2    = in2[M:0];
    assign sgn_c = in1[W-1] ^ in2[W-1];
    assign nan1  = (&e1) & (|f1);
    assign nan2  = (&e2) & (|f2);
    assign inf1  = (&e1) & ~(|f1);
    assign inf2  = (&e2) & ~(|f2);
    // Exponent zero covers subnormals, which are flushed to signed zero.
    assign zero1 = ~(|e1);
    assign zero2 = ~(|e2);

    divxbit #(.MW(MW), .QW(QW)) u_divxbit (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .en       (iter_c),
        .a        ({1'b1, f1}),
        .b        ({1'b1, f2}),
        .q        (quo),
        .rem_nz_c (rem_nz_c),
        .last_c   (last_c)
    );

    // Special-operand resolution in priority order.
    always_comb begin
        spc_c   = 1'b1;
        spc_out = '0;
        spc_ov  = 1'b0;
        spc_inv = 1'b0;
        spc_dz  = 1'b0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spc_out = W'(FP_NANQ);
            spc_inv = 1'b1;
        end else if (inf1) begin
            spc_out = sgn_c ? W'(FP_INFN) : W'(FP_INFP);
        end else if (inf2 || zero1) begin
            spc_out = sgn_c ? W'(FP_ZERON) : W'(FP_ZEROP);
        end else if (zero2) begin
            spc_out = sgn_c ? W'(FP_INFN) : W'(FP_INFP);
`ifdef FP_DIV_DZ_FLAG_EN
            spc_dz  = 1'b1;
`else
            spc_ov  = 1'b1;
`endif
        end else begin
            spc_c = 1'b0;
        end
    end

    // Normalize, round and range-check the finished quotient.
    always_comb begin
        if (quo[QW-1]) begin
            mant = quo[QW-1:2];
            g    = quo[1];
            s    = quo[0] | rem_nz_c;
            ex   = exp0;
        end else begin
            mant = quo[QW-2:1];
            g    = quo[0];
            s    = rem_nz_c;
            ex   = exp0 - XW'(1);
        end
        inc     = round_inc(rm, sgn, mant[0], g, s);
        mant_r  = {1'b0, mant} + {{MW{1'b0}}, inc};
        frac    = mant_r[MW] ? '0 : mant_r[FW-1:0];
        if (mant_r[MW]) ex = ex + XW'(1);
        rnd_ov  = 1'b0;
        rnd_un  = 1'b0;
        rnd_inx = g | s;
        rnd_out = {sgn, ex[EW-1:0], frac};
        if (!ex[XW-1] && ex > XW'(EMAX)) begin
            rnd_out = sgn ? W'(FP_INFN) : W'(FP_INFP);
            rnd_ov  = 1'b1;
            rnd_inx = 1'b1;
        end else if (ex[XW-1] || ex == '0) begin
            rnd_out = sgn ? W'(FP_ZERON) : W'(FP_ZEROP);
            rnd_un  = 1'b1;
            rnd_inx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        iter_c    = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    if (spc_c) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = DIV;
                        load_c    = 1'b1;
                    end
                end
            end
            DIV: begin
                iter_c = 1'b1;
                if (last_c) state_nxt = ROUND;
            end
            ROUND:   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result staging: specials captured at accept, normals at ROUND, published in FIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn     <= 1'b0;
            rm      <= RNe;
            exp0    <= '0;
            res_out <= '0;
            res_ov  <= 1'b0;
            res_un  <= 1'b0;
            res_inv <= 1'b0;
            res_inx <= 1'b0;
            res_dz  <= 1'b0;
            out     <= '0;
            ov      <= 1'b0;
            un      <= 1'b0;
            inv     <= 1'b0;
            inexact <= 1'b0;
`ifdef FP_DIV_DZ_FLAG_EN
            dz      <= 1'b0;
`endif
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt == DIV) || (state_nxt == ROUND);
            if (state == IDLE && act) begin
                sgn     <= sgn_c;
                rm      <= round_m;
                exp0    <= XW'(e1) - XW'(e2) + XW'(FP_BIAS);
                res_out <= spc_out;
                res_ov  <= spc_ov;
                res_un  <= 1'b0;
                res_inv <= spc_inv;
                res_inx <= 1'b0;
                res_dz  <= spc_dz;
            end
            if (state == ROUND) begin
                res_out <= rnd_out;
                res_ov  <= rnd_ov;
                res_un  <= rnd_un;
                res_inv <= 1'b0;
                res_inx <= rnd_inx;
                res_dz  <= 1'b0;
            end
            if (state == FIN) begin
                out     <= res_out;
                ov      <= res_ov;
                un      <= res_un;
                inv     <= res_inv;
                inexact <= res_inx;
`ifdef FP_DIV_DZ_FLAG_EN
                dz      <= res_dz;
`endif
                done    <= 1'b1;
            end
        end
    end

`ifndef FP_DIV_DZ_FLAG_EN
    logic unused_dz;
    assign unused_dz = res_dz;
`endif

endmodule
